// File: rtl/nios_system_sysid_checker.sv
// System-ID checker: Avalon-MM read master that fetches the sysid ID and
// timestamp words and reports match / mismatch / waitrequest timeout.
module nios_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1580380136,
    parameter int unsigned READ_LATENCY   = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        address,
    output logic        read,
    input  logic [31:0] readdata,
    input  logic        waitrequest,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        match,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [2:0] {
        IDLE,
        REQ_ID,
        LAT_ID,
        REQ_TS,
        LAT_TS,
        FINISH
    } state_t;

    localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  LAT_LAST   = (READ_LATENCY == 0) ? 2'd0 : 2'(READ_LATENCY - 1);

    state_t      state;
    logic        auto_pend;
    logic [15:0] stall_cnt;
    logic [1:0]  lat_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            auto_pend   <= AUTO_START;
            stall_cnt   <= '0;
            lat_cnt     <= '0;
            address     <= 1'b0;
            read        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            match       <= 1'b0;
            timeout_err <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start || auto_pend) begin
                        auto_pend   <= 1'b0;
                        state       <= REQ_ID;
                        busy        <= 1'b1;
                        read        <= 1'b1;
                        address     <= 1'b0;
                        stall_cnt   <= '0;
                        id_ok       <= 1'b0;
                        ts_ok       <= 1'b0;
                        match       <= 1'b0;
                        timeout_err <= 1'b0;
                    end
                end

                REQ_ID: begin
                    if (!waitrequest) begin
                        stall_cnt <= '0;
                        if (READ_LATENCY == 0) begin
                            // Zero latency: capture in the accept cycle and issue the TS read next.
                            id_value <= readdata;
                            address  <= 1'b1;
                            state    <= REQ_TS;
                        end else begin
                            read    <= 1'b0;
                            lat_cnt <= '0;
                            state   <= LAT_ID;
                        end
                    end else if (stall_cnt == STALL_LAST) begin
                        read        <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= FINISH;
                    end else begin
                        stall_cnt <= stall_cnt + 16'd1;
                    end
                end

                LAT_ID: begin
                    if (lat_cnt == LAT_LAST) begin
                        id_value  <= readdata;
                        read      <= 1'b1;
                        address   <= 1'b1;
                        stall_cnt <= '0;
                        state     <= REQ_TS;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end

                REQ_TS: begin
                    if (!waitrequest) begin
                        stall_cnt <= '0;
                        read      <= 1'b0;
                        if (READ_LATENCY == 0) begin
                            ts_value <= readdata;
                            state    <= FINISH;
                        end else begin
                            lat_cnt <= '0;
                            state   <= LAT_TS;
                        end
                    end else if (stall_cnt == STALL_LAST) begin
                        read        <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= FINISH;
                    end else begin
                        stall_cnt <= stall_cnt + 16'd1;
                    end
                end

                LAT_TS: begin
                    if (lat_cnt == LAT_LAST) begin
                        ts_value <= readdata;
                        state    <= FINISH;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end

                FINISH: begin
                    if (!timeout_err) begin
                        id_ok <= (id_value == EXPECTED_ID);
                        ts_ok <= (ts_value == EXPECTED_TS);
                        match <= (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS);
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nios_system_sysid_checker.sv
// Directed bench: instance A uses defaults (auto start, zero latency); instance B
// uses READ_LATENCY=2, TIMEOUT_CYCLES=8, AUTO_START=0 and EXPECTED_TS=0x5E320FE9.
module tb_nios_system_sysid_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A
    logic        rst_a, start_a, addr_a, read_a, busy_a, done_a;
    logic        idok_a, tsok_a, match_a, to_a;
    logic [31:0] rdata_a, idv_a, tsv_a;
    logic        wait_a = 1'b0;

    assign rdata_a = read_a ? (addr_a ? 32'd1580380136 : 32'd0) : 32'hDEAD_BEEF;

    nios_system_sysid_checker dut_a (
        .clock(clk), .reset_n(rst_a), .start(start_a), .address(addr_a), .read(read_a),
        .readdata(rdata_a), .waitrequest(wait_a), .busy(busy_a), .done(done_a),
        .id_ok(idok_a), .ts_ok(tsok_a), .match(match_a), .timeout_err(to_a),
        .id_value(idv_a), .ts_value(tsv_a)
    );

    // Instance B
    logic        rst_b, start_b, addr_b, read_b, busy_b, done_b, wait_b;
    logic        idok_b, tsok_b, match_b, to_b;
    logic [31:0] rdata_b, idv_b, tsv_b, pipe_b, ts_word_b;

    // Two-cycle slave: data for an access accepted at edge k is valid for the capture at edge k+2.
    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            pipe_b  <= 32'hDEAD_BEEF;
            rdata_b <= 32'hDEAD_BEEF;
        end else begin
            pipe_b  <= (read_b && !wait_b) ? (addr_b ? ts_word_b : 32'd0) : 32'hDEAD_BEEF;
            rdata_b <= pipe_b;
        end
    end

    nios_system_sysid_checker #(
        .EXPECTED_TS(32'h5E32_0FE9), .READ_LATENCY(2), .TIMEOUT_CYCLES(8), .AUTO_START(1'b0)
    ) dut_b (
        .clock(clk), .reset_n(rst_b), .start(start_b), .address(addr_b), .read(read_b),
        .readdata(rdata_b), .waitrequest(wait_b), .busy(busy_b), .done(done_b),
        .id_ok(idok_b), .ts_ok(tsok_b), .match(match_b), .timeout_err(to_b),
        .id_value(idv_b), .ts_value(tsv_b)
    );

    task automatic test_reset;
        checks++;
        if ({addr_a, read_a, busy_a, done_a, idok_a, tsok_a, match_a, to_a} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl_a got %b want 00000000",
                     {addr_a, read_a, busy_a, done_a, idok_a, tsok_a, match_a, to_a});
        end
        checks++;
        if ({idv_a, tsv_a} !== 64'd0) begin
            errors++;
            $display("FAIL reset_values_a got %h want 0", {idv_a, tsv_a});
        end
        checks++;
        if ({addr_b, read_b, busy_b, done_b, idok_b, tsok_b, match_b, to_b} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl_b got %b want 00000000",
                     {addr_b, read_b, busy_b, done_b, idok_b, tsok_b, match_b, to_b});
        end
    endtask

    // Edge 1 after release: IDLE auto-starts; reads at edges 1,2; FINISH at 3; done at 4.
    task automatic test_auto_start;
        logic [8:1] rd_bits, ad_bits, dn_bits;
        rd_bits = '0; ad_bits = '0; dn_bits = '0;
        @(negedge clk) rst_a = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            rd_bits[i] = read_a;
            ad_bits[i] = read_a & addr_a;
            dn_bits[i] = done_a;
            if (i == 4) begin
                checks++;
                if ({busy_a, idok_a, tsok_a, match_a, to_a} !== 5'b01110) begin
                    errors++;
                    $display("FAIL auto_status got %b want 01110",
                             {busy_a, idok_a, tsok_a, match_a, to_a});
                end
            end
        end
        checks++;
        if (rd_bits !== 8'b0000_0011) begin
            errors++;
            $display("FAIL auto_read_seq got %b want 00000011", rd_bits);
        end
        checks++;
        if (ad_bits !== 8'b0000_0010) begin
            errors++;
            $display("FAIL auto_addr_seq got %b want 00000010", ad_bits);
        end
        checks++;
        if (dn_bits !== 8'b0000_1000) begin
            errors++;
            $display("FAIL auto_done_seq got %b want 00001000", dn_bits);
        end
    endtask

    task automatic test_back_to_back;
        int ndone, nread, guard;
        ndone = 0; nread = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk) start_a = (i < 4);
            @(posedge clk); #1;
            if (done_a) ndone++;
            if (read_a) nread++;
        end
        start_a = 1'b0;
        checks++;
        if (ndone !== 1) begin
            errors++;
            $display("FAIL busy_start_done_count got %0d want 1", ndone);
        end
        checks++;
        if (nread !== 2) begin
            errors++;
            $display("FAIL busy_start_read_count got %0d want 2", nread);
        end
        @(negedge clk) start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        checks++;
        if ({busy_a, idok_a, tsok_a, match_a} !== 4'b1000) begin
            errors++;
            $display("FAIL restart_clear got %b want 1000", {busy_a, idok_a, tsok_a, match_a});
        end
        guard = 0;
        while (!done_a && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (!(done_a === 1'b1 && match_a === 1'b1)) begin
            errors++;
            $display("FAIL restart_match got done=%b match=%b want 1 1", done_a, match_a);
        end
    endtask

    // Starts a check on B (edge 0 samples start) and returns the edge index of done, or -1.
    task automatic run_b(output int done_edge);
        done_edge = -1;
        @(negedge clk) start_b = 1'b1;
        for (int e = 0; e < 40 && done_edge < 0; e++) begin
            @(posedge clk); #1;
            start_b = 1'b0;
            if (done_b) done_edge = e;
        end
        checks++;
        if (done_edge < 0) begin
            errors++;
            $display("FAIL done_b_timeout got none want done within 40 cycles");
        end
    endtask

    task automatic test_no_auto_b;
        @(negedge clk) rst_b = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({busy_b, read_b, done_b} !== 3'b000) begin
            errors++;
            $display("FAIL no_auto_start got %b want 000", {busy_b, read_b, done_b});
        end
    endtask

    task automatic test_ts_mismatch;
        int de;
        ts_word_b = 32'h5E32_0FE8;
        run_b(de);
        checks++;
        if (de !== 7) begin
            errors++;
            $display("FAIL lat2_done_cycle got %0d want 7", de);
        end
        checks++;
        if ({idok_b, tsok_b, match_b, to_b} !== 4'b1000) begin
            errors++;
            $display("FAIL ts_mismatch_flags got %b want 1000", {idok_b, tsok_b, match_b, to_b});
        end
        checks++;
        if (tsv_b !== 32'h5E32_0FE8) begin
            errors++;
            $display("FAIL ts_mismatch_value got %h want 5e320fe8", tsv_b);
        end
    endtask

    task automatic test_latency_stall;
        int stable, de;
        ts_word_b = 32'h5E32_0FE9;
        stable = 0; de = -1;
        wait_b = 1'b1;
        @(negedge clk) start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk); #1;
            if (read_b && !addr_b) stable++;
        end
        @(negedge clk) wait_b = 1'b0;
        for (int e = 5; e < 40 && de < 0; e++) begin
            @(posedge clk); #1;
            if (done_b) de = e;
        end
        checks++;
        if (stable !== 4) begin
            errors++;
            $display("FAIL stall_addr_stable got %0d want 4", stable);
        end
        checks++;
        if (de !== 11) begin
            errors++;
            $display("FAIL stall_done_cycle got %0d want 11", de);
        end
        checks++;
        if ({idok_b, tsok_b, match_b, to_b} !== 4'b1110 || idv_b !== 32'd0) begin
            errors++;
            $display("FAIL stall_match got flags=%b id=%h want 1110 id=0",
                     {idok_b, tsok_b, match_b, to_b}, idv_b);
        end
    endtask

    // Stall counter hits 7 at edge 8: read high after edges 0..7, done after edge 9.
    task automatic test_timeout;
        int nread, ndone, de;
        nread = 0; ndone = 0; de = -1;
        wait_b = 1'b1;
        @(negedge clk) start_b = 1'b1;
        for (int e = 0; e < 14; e++) begin
            @(posedge clk); #1;
            start_b = 1'b0;
            if (read_b) nread++;
            if (done_b) begin
                ndone++;
                de = e;
            end
        end
        wait_b = 1'b0;
        checks++;
        if (nread !== 8) begin
            errors++;
            $display("FAIL timeout_read_cycles got %0d want 8", nread);
        end
        checks++;
        if (ndone !== 1 || de !== 9) begin
            errors++;
            $display("FAIL timeout_done got count=%0d edge=%0d want 1 9", ndone, de);
        end
        checks++;
        if ({to_b, match_b, busy_b} !== 3'b100) begin
            errors++;
            $display("FAIL timeout_flags got %b want 100", {to_b, match_b, busy_b});
        end
    endtask

    task automatic test_reset_mid;
        int de;
        ts_word_b = 32'h5E32_0FE9;
        @(negedge clk) start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        checks++;
        if ({busy_b, read_b} !== 2'b10) begin
            errors++;
            $display("FAIL lat_ts_state got busy,read=%b want 10", {busy_b, read_b});
        end
        rst_b = 1'b0;
        #1;
        checks++;
        if ({addr_b, read_b, busy_b, done_b, idok_b, tsok_b, match_b, to_b} !== 8'h00
            || tsv_b !== 32'd0 || idv_b !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset got ctrl=%b ts=%h id=%h want 0",
                     {addr_b, read_b, busy_b, done_b, idok_b, tsok_b, match_b, to_b}, tsv_b, idv_b);
        end
        @(negedge clk) rst_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy_b, read_b} !== 2'b00) begin
            errors++;
            $display("FAIL post_reset_idle got %b want 00", {busy_b, read_b});
        end
        run_b(de);
        checks++;
        if (match_b !== 1'b1 || tsv_b !== 32'h5E32_0FE9) begin
            errors++;
            $display("FAIL post_reset_match got match=%b ts=%h want 1 5e320fe9", match_b, tsv_b);
        end
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        wait_b = 1'b0;
        ts_word_b = 32'h5E32_0FE9;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_auto_start();
        test_back_to_back();
        test_no_auto_b();
        test_ts_mismatch();
        test_latency_stall();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
